duck_motion_ctl: RTL and testbench

- Producer of the duck position consumed by the game-logic block: drives duck_xpos/duck_ypos, the hit box top-left corner, duck 96x60 px.
- Consumes hunt_start and duck_killed from the game-logic block.
- Flies the duck with edge bounce, freezes and drops it on a kill, hides it, then respawns it on the next hunt.
- Sits between the game control and the duck sprite renderer, on the 65 MHz pixel clock (1024x768).

---
 rtl/duck_pkg.sv | 25 ++
 rtl/duck_motion_ctl_lfsr16.sv | 26 ++
 rtl/duck_motion_ctl.sv | 227 ++++++++++++++++++++++
 tb/tb_duck_motion_ctl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared types and constants for the duck motion controller.
// Game logic and the sprite renderer import the hit box size from here.
package duck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FLYING,
    SHOT,
    FALLING,
    GONE
  } duck_state_t;

  localparam int DUCK_W = 96;
  localparam int DUCK_H = 60;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/duck_motion_ctl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the spawn point.
// A maximal-length polynomial with a non-zero seed never reaches zero.
module lfsr16
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_fb(lfsr_q)};

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/duck_motion_ctl.sv
// Duck flight controller: bounce flight, hit freeze, fall, hide, respawn.
// Drives the hit box top-left corner for game logic and the renderer.
module duck_motion_ctl
  import duck_pkg::*;
#(
  parameter int H_RES        = 1024,
  parameter int GROUND_Y     = 600,
  parameter int SKY_Y        = 40,
  parameter int MOVE_DIV     = 65_000,
  parameter int FLY_STEP     = 2,
  parameter int FALL_STEP    = 3,
  parameter int HIT_TICKS    = 500,
  parameter int FRAME_TICKS  = 100,
  parameter int SPAWN_X_BASE = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        hunt_start,
  input  logic        duck_killed,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic        duck_dir,
  output logic [1:0]  duck_frame,
  output logic        duck_visible,
  output logic        duck_falling
);

  localparam int X_MAX = H_RES - DUCK_W;
  localparam int Y_MAX = GROUND_Y - DUCK_H;
  localparam int PW = $clog2(MOVE_DIV + 1);
  localparam int FW = $clog2(FRAME_TICKS + 1);
  localparam int HW = $clog2(HIT_TICKS + 1);

  localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
  localparam logic signed [12:0] SKY_S   = 13'(SKY_Y);
  localparam logic signed [12:0] STEP_S  = 13'(FLY_STEP);
  localparam logic signed [12:0] FALL_S  = 13'(FALL_STEP);
  localparam logic signed [12:0] BASE_S  = 13'(SPAWN_X_BASE);

  duck_state_t state_q, state_d;

  logic [PW-1:0] pre_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic          dir_q, dir_d, vup_q, vup_d;
  logic [1:0]    frame_q, frame_d;
  logic          vis_q, vis_d, fall_q, fall_d;
  logic          hunt_q, kill_q;

  logic          tick, hunt_rise, kill_rise;
  logic [15:0]   lfsr_w;
  logic          lfsr_unused;

  logic signed [12:0] x_s, y_s, nx, ny;
  logic signed [12:0] fly_x, fly_y, fall_y, spawn_x;
  logic               fly_dir, fly_vup, fall_land;

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr_w)
  );

  assign lfsr_unused = ^lfsr_w[15:10];

  assign tick      = (pre_q == '0);
  assign hunt_rise = hunt_start & ~hunt_q;
  assign kill_rise = duck_killed & ~kill_q;

  assign x_s = $signed({1'b0, x_q});
  assign y_s = $signed({1'b0, y_q});

  always_comb begin
    nx      = dir_q ? x_s + STEP_S : x_s - STEP_S;
    ny      = vup_q ? y_s - STEP_S : y_s + STEP_S;
    fly_x   = nx;
    fly_dir = dir_q;
    fly_y   = ny;
    fly_vup = vup_q;
    if (nx > X_MAX_S) begin
      fly_x   = X_MAX_S;
      fly_dir = ~dir_q;
    end else if (nx < 13'sd0) begin
      fly_x   = '0;
      fly_dir = ~dir_q;
    end
    if (ny > Y_MAX_S) begin
      fly_y   = Y_MAX_S;
      fly_vup = ~vup_q;
    end else if (ny < SKY_S) begin
      fly_y   = SKY_S;
      fly_vup = ~vup_q;
    end
    fall_y    = y_s + FALL_S;
    fall_land = (fall_y >= Y_MAX_S);
    spawn_x   = BASE_S + $signed({4'b0, lfsr_w[8:0]});
    if (spawn_x > X_MAX_S) begin
      spawn_x = X_MAX_S;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    vup_d   = vup_q;
    frame_d = frame_q;
    fcnt_d  = fcnt_q;
    hcnt_d  = hcnt_q;
    vis_d   = vis_q;
    fall_d  = fall_q;
    if (!game_enable) begin
      state_d = IDLE;
      vis_d   = 1'b0;
      fall_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          vis_d  = 1'b0;
          fall_d = 1'b0;
          if (hunt_start) state_d = SPAWN;
        end
        SPAWN: begin
          x_d     = spawn_x[11:0];
          y_d     = Y_MAX_S[11:0];
          dir_d   = lfsr_w[9];
          vup_d   = 1'b1;
          frame_d = 2'd0;
          fcnt_d  = '0;
          vis_d   = 1'b1;
          fall_d  = 1'b0;
          state_d = FLYING;
        end
        FLYING: begin
          // A kill freezes the pre-tick position even if a bounce is due.
          if (kill_rise) begin
            state_d = SHOT;
            frame_d = 2'd3;
            fall_d  = 1'b1;
            hcnt_d  = '0;
          end else if (tick && hunt_start) begin
            x_d   = fly_x[11:0];
            y_d   = fly_y[11:0];
            dir_d = fly_dir;
            vup_d = fly_vup;
            if (fcnt_q == FW'(FRAME_TICKS - 1)) begin
              fcnt_d  = '0;
              frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        SHOT: begin
          if (tick) begin
            if (hcnt_q == HW'(HIT_TICKS - 1)) begin
              state_d = FALLING;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        FALLING: begin
          if (tick) begin
            if (fall_land) begin
              y_d     = Y_MAX_S[11:0];
              vis_d   = 1'b0;
              fall_d  = 1'b0;
              state_d = GONE;
            end else begin
              y_d = fall_y[11:0];
            end
          end
        end
        GONE: begin
          vis_d = 1'b0;
          if (hunt_rise) state_d = SPAWN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= PW'(MOVE_DIV - 1);
      state_q <= IDLE;
      x_q     <= BASE_S[11:0];
      y_q     <= Y_MAX_S[11:0];
      dir_q   <= 1'b1;
      vup_q   <= 1'b1;
      frame_q <= 2'd0;
      fcnt_q  <= '0;
      hcnt_q  <= '0;
      vis_q   <= 1'b0;
      fall_q  <= 1'b0;
      hunt_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      pre_q   <= tick ? PW'(MOVE_DIV - 1) : pre_q - 1'b1;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      vup_q   <= vup_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
      hcnt_q  <= hcnt_d;
      vis_q   <= vis_d;
      fall_q  <= fall_d;
      hunt_q  <= hunt_start;
      kill_q  <= duck_killed;
    end
  end

  assign duck_xpos    = x_q;
  assign duck_ypos    = y_q;
  assign duck_dir     = dir_q;
  assign duck_frame   = frame_q;
  assign duck_visible = vis_q;
  assign duck_falling = fall_q;

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Randomised scoreboard bench for duck_motion_ctl against a behavioural model.
// Short tick/timer settings keep full flights, bounces and falls within budget.
module tb_duck_motion_ctl;

  localparam int MOVE_DIV    = 4;
  localparam int HIT_TICKS   = 5;
  localparam int FRAME_TICKS = 2;
  localparam int XMAX  = 1024 - 96;
  localparam int YMAX  = 600 - 60;
  localparam int SKY   = 40;
  localparam int XBASE = 200;
  localparam int NCYC  = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_enable = 1'b1;
  logic        hunt_start = 1'b1;
  logic        duck_killed = 1'b0;
  logic [11:0] duck_xpos;
  logic [11:0] duck_ypos;
  logic        duck_dir;
  logic [1:0]  duck_frame;
  logic        duck_visible;
  logic        duck_falling;

  duck_motion_ctl #(
    .MOVE_DIV    (MOVE_DIV),
    .HIT_TICKS   (HIT_TICKS),
    .FRAME_TICKS (FRAME_TICKS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_enable  (game_enable),
    .hunt_start   (hunt_start),
    .duck_killed  (duck_killed),
    .duck_xpos    (duck_xpos),
    .duck_ypos    (duck_ypos),
    .duck_dir     (duck_dir),
    .duck_frame   (duck_frame),
    .duck_visible (duck_visible),
    .duck_falling (duck_falling)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit dir;
    int frame;
    bit vis;
    bit fall;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  typedef enum {M_IDLE, M_SPAWN, M_FLY, M_SHOT, M_FALL, M_GONE} phase_t;
  phase_t ph = M_IDLE;
  int mx, my, mframe, fly_ticks, shot_ticks, since_rst;
  bit mdir, mup, mvis, mfall, hprev, kprev;
  bit [15:0] mlfsr;

  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Advance the reference by one clock edge using the inputs now applied.
  task automatic model_step();
    bit tick, hrise, krise;
    bit [15:0] cur;
    if (rst) begin
      ph = M_IDLE; mx = XBASE; my = YMAX; mdir = 1; mup = 1;
      mframe = 0; mvis = 0; mfall = 0; fly_ticks = 0; shot_ticks = 0;
      since_rst = 0; hprev = 0; kprev = 0; mlfsr = 16'hACE1;
      return;
    end
    tick = (since_rst % MOVE_DIV) == MOVE_DIV - 1;
    since_rst++;
    hrise = hunt_start && !hprev;
    krise = duck_killed && !kprev;
    cur = mlfsr;
    mlfsr = lfsr_next(mlfsr);
    hprev = hunt_start;
    kprev = duck_killed;
    if (!game_enable) begin
      ph = M_IDLE; mvis = 0; mfall = 0;
      return;
    end
    case (ph)
      M_IDLE: if (hunt_start) ph = M_SPAWN;
      M_SPAWN: begin
        mx = XBASE + int'(cur & 16'h01FF);
        my = YMAX; mdir = cur[9]; mup = 1; mframe = 0;
        fly_ticks = 0; mvis = 1; mfall = 0; ph = M_FLY;
      end
      M_FLY: begin
        if (krise) begin
          ph = M_SHOT; mframe = 3; mfall = 1; shot_ticks = 0;
        end else if (tick && hunt_start) begin
          mx += mdir ? 2 : -2;
          if (mx > XMAX) begin mx = XMAX; mdir = 0; end
          else if (mx < 0) begin mx = 0; mdir = 1; end
          my += mup ? -2 : 2;
          if (my < SKY) begin my = SKY; mup = 0; end
          else if (my > YMAX) begin my = YMAX; mup = 1; end
          fly_ticks++;
          mframe = (fly_ticks / FRAME_TICKS) % 3;
        end
      end
      M_SHOT: if (tick) begin
        shot_ticks++;
        if (shot_ticks == HIT_TICKS) ph = M_FALL;
      end
      M_FALL: if (tick) begin
        my += 3;
        if (my >= YMAX) begin
          my = YMAX; mvis = 0; mfall = 0; ph = M_GONE;
        end
      end
      M_GONE: if (hrise) ph = M_SPAWN;
      default: ph = M_IDLE;
    endcase
  endtask

  initial begin
    int ge_low, h_low, k_hi;
    ge_low = 0; h_low = 0; k_hi = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = (c < 3) || (c == NCYC / 2) || ($urandom_range(0, 19999) == 0);
      if (ge_low > 0) begin
        game_enable = 1'b0; ge_low--;
      end else begin
        game_enable = 1'b1;
        if ($urandom_range(0, (ph == M_FALL) ? 299 : 3999) == 0)
          ge_low = $urandom_range(1, 6);
      end
      if (h_low > 0) begin
        hunt_start = 1'b0; h_low--;
      end else begin
        hunt_start = 1'b1;
        if (ph == M_FLY && $urandom_range(0, 1499) == 0)
          h_low = $urandom_range(20, 120);
        else if (ph == M_GONE && $urandom_range(0, 7) == 0)
          h_low = $urandom_range(2, 30);
      end
      if (k_hi > 0) begin
        duck_killed = 1'b1; k_hi--;
      end else begin
        duck_killed = 1'b0;
        if ((ph == M_FLY && $urandom_range(0, 1999) == 0) ||
            $urandom_range(0, 2999) == 0)
          k_hi = $urandom_range(1, 15);
      end
      model_step();
      sb.push_back('{mx, my, mdir, mframe, mvis, mfall});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (duck_xpos !== 12'(e.x) || duck_ypos !== 12'(e.y) ||
            duck_dir !== e.dir || duck_frame !== 2'(e.frame) ||
            duck_visible !== e.vis || duck_falling !== e.fall) begin
          errors++;
          $display("FAIL outputs t=%0t got x=%0d y=%0d dir=%b fr=%0d vis=%b fall=%b required x=%0d y=%0d dir=%b fr=%0d vis=%b fall=%b",
                   $time, duck_xpos, duck_ypos, duck_dir, duck_frame,
                   duck_visible, duck_falling, e.x, e.y, e.dir, e.frame,
                   e.vis, e.fall);
        end
      end
    end
  end

endmodule
